// File: rtl/ram_arbiter.sv
// Arbitrates the shared program/data RAM between the bios loader and the CPU data and fetch ports.
// A tag pipeline routes every read word back to the requester that issued it.

module ram_arbiter_rsp #(
   parameter int DATA_WIDTH = 31
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                vld,
   input  logic [DATA_WIDTH:0] ram_rdata,
   output logic                rvalid,
   output logic [DATA_WIDTH:0] rdata
);
   logic [DATA_WIDTH:0] hold_q;

   // Ports that did not receive this word keep showing their last one.
   always_ff @(posedge clk) begin
      if (rst)      hold_q <= '0;
      else if (vld) hold_q <= ram_rdata;
   end

   assign rvalid = vld;
   assign rdata  = vld ? ram_rdata : hold_q;
endmodule

module ram_arbiter #(
   parameter int ADDR_WIDTH   = 31,
   parameter int DATA_WIDTH   = 31,
   parameter int READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                clk_en,
   input  logic                rst,
   input  logic                i_booted,
   input  logic                i_b_req,
   input  logic                i_b_we,
   input  logic [3:0]          i_b_be,
   input  logic [ADDR_WIDTH:0] i_b_addr,
   input  logic [DATA_WIDTH:0] i_b_wdata,
   output logic                o_b_gnt,
   output logic                o_b_rvalid,
   output logic [DATA_WIDTH:0] o_b_rdata,
   input  logic                i_d_req,
   input  logic                i_d_we,
   input  logic [3:0]          i_d_be,
   input  logic [ADDR_WIDTH:0] i_d_addr,
   input  logic [DATA_WIDTH:0] i_d_wdata,
   output logic                o_d_gnt,
   output logic                o_d_rvalid,
   output logic [DATA_WIDTH:0] o_d_rdata,
   input  logic                i_f_req,
   input  logic [ADDR_WIDTH:0] i_f_addr,
   output logic                o_f_gnt,
   output logic                o_f_rvalid,
   output logic [DATA_WIDTH:0] o_f_rdata,
   output logic                o_ram_en,
   output logic                o_ram_we,
   output logic [3:0]          o_ram_be,
   output logic [ADDR_WIDTH:0] o_ram_addr,
   output logic [DATA_WIDTH:0] o_ram_wdata,
   input  logic [DATA_WIDTH:0] i_ram_rdata,
   output logic                o_busy
);
   localparam int NUM_PORTS = 3;
   localparam int B = 2;
   localparam int D = 1;
   localparam int F = 0;
   localparam int CNT_W = $clog2(READ_LATENCY + 1);

   typedef struct packed {
      logic                we;
      logic [3:0]          be;
      logic [ADDR_WIDTH:0] addr;
      logic [DATA_WIDTH:0] wdata;
   } cmd_t;

   typedef enum logic [1:0] {LOCKED, SHARED, DRAIN} state_t;

   state_t                          state_q, state_d;
   logic                            ptr_q;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [NUM_PORTS-1:0]            req, gnt, rd_tag, rvalid;
   cmd_t [NUM_PORTS-1:0]            cmd;
   cmd_t                            ram_cmd;
   logic [READ_LATENCY:1][NUM_PORTS-1:0]      tag_pipe;
   logic [NUM_PORTS-1:0][DATA_WIDTH:0]        rdata;

   assign req = {i_b_req, i_d_req, i_f_req};

   always_comb begin
      cmd    = '0;
      cmd[B] = '{we: i_b_we, be: i_b_be, addr: i_b_addr, wdata: i_b_wdata};
      cmd[D] = '{we: i_d_we, be: i_d_be, addr: i_d_addr, wdata: i_d_wdata};
      cmd[F] = '{we: 1'b0, be: 4'hF, addr: i_f_addr, wdata: '0};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LOCKED;
         ptr_q   <= 1'b0;
         cnt_q   <= '0;
      end else if (clk_en) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (gnt[D] || gnt[F]) ptr_q <= ~ptr_q;
      end
   end

   // Grants are combinational and suppressed while reset or the clock enable is low.
   always_comb begin
      state_d = state_q;
      gnt     = '0;
      if (clk_en && !rst) begin
         case (state_q)
            LOCKED: begin
               gnt[B] = req[B];
               if (i_booted) state_d = SHARED;
            end
            SHARED: begin
               if (req[B])                 gnt[B] = 1'b1;
               else if (req[D] && req[F]) begin
                  if (ptr_q) gnt[F] = 1'b1;
                  else       gnt[D] = 1'b1;
               end
               else if (req[D])            gnt[D] = 1'b1;
               else if (req[F])            gnt[F] = 1'b1;
               if (!i_booted) state_d = DRAIN;
            end
            DRAIN: begin
               if (cnt_q == '0) state_d = LOCKED;
            end
            default: state_d = LOCKED;
         endcase
      end
   end

   always_comb begin
      ram_cmd = cmd[D];
      if (gnt[B])      ram_cmd = cmd[B];
      else if (gnt[F]) ram_cmd = cmd[F];
   end

   assign o_ram_en    = |gnt;
   assign o_ram_we    = ram_cmd.we;
   assign o_ram_be    = ram_cmd.be;
   assign o_ram_addr  = ram_cmd.addr;
   assign o_ram_wdata = ram_cmd.wdata;

   // Writes enter the pipeline as an empty tag so read slots stay aligned with RAM latency.
   assign rd_tag = gnt & {NUM_PORTS{~ram_cmd.we}};

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_pipe <= '0;
      end else if (clk_en) begin
         tag_pipe[1] <= rd_tag;
         for (int s = 2; s <= READ_LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
      end
   end

   assign rvalid = tag_pipe[READ_LATENCY] & {NUM_PORTS{clk_en & ~rst}};

   always_comb begin
      cnt_d = cnt_q;
      if (|rd_tag) cnt_d = cnt_d + CNT_W'(1);
      if (|rvalid) cnt_d = cnt_d - CNT_W'(1);
   end

   assign o_busy = (cnt_q != '0) || (state_q != SHARED);

   logic [NUM_PORTS-1:0] rv_out;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
      ram_arbiter_rsp #(.DATA_WIDTH(DATA_WIDTH)) u_rsp (
         .clk       (clk),
         .rst       (rst),
         .vld       (rvalid[p]),
         .ram_rdata (i_ram_rdata),
         .rvalid    (rv_out[p]),
         .rdata     (rdata[p])
      );
   end

   assign o_b_gnt    = gnt[B];
   assign o_d_gnt    = gnt[D];
   assign o_f_gnt    = gnt[F];
   assign o_b_rvalid = rv_out[B];
   assign o_d_rvalid = rv_out[D];
   assign o_f_rvalid = rv_out[F];
   assign o_b_rdata  = rdata[B];
   assign o_d_rdata  = rdata[D];
   assign o_f_rdata  = rdata[F];

   a_gnt_onehot: assert property (@(posedge clk) $onehot0(gnt));
   a_cnt_bound:  assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_W'(READ_LATENCY));
   a_drain_idle: assert property (@(posedge clk) disable iff (rst) (state_q == DRAIN) |-> (gnt == '0));
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one instance at READ_LATENCY=1 and one at 3,
// each backed by a small RAM model honouring clk_en and byte enables.

module tb_ram_arbiter;
   logic        clk = 1'b0;
   logic        clk_en, rst, booted;
   logic        b_req, b_we, d_req, d_we, f_req;
   logic [3:0]  b_be, d_be;
   logic [31:0] b_addr, b_wdata, d_addr, d_wdata, f_addr;

   logic        b_gnt1, b_rv1, d_gnt1, d_rv1, f_gnt1, f_rv1, ram_en1, ram_we1, busy1;
   logic [31:0] b_rd1, d_rd1, f_rd1, ram_addr1, ram_wdata1, ram_rdata1;
   logic [3:0]  ram_be1;
   logic        b_gnt3, b_rv3, d_gnt3, d_rv3, f_gnt3, f_rv3, ram_en3, ram_we3, busy3;
   logic [31:0] b_rd3, d_rd3, f_rd3, ram_addr3, ram_wdata3, ram_rdata3;
   logic [3:0]  ram_be3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ram_arbiter #(.ADDR_WIDTH(31), .DATA_WIDTH(31), .READ_LATENCY(1)) dut1 (
      .clk(clk), .clk_en(clk_en), .rst(rst), .i_booted(booted),
      .i_b_req(b_req), .i_b_we(b_we), .i_b_be(b_be), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
      .o_b_gnt(b_gnt1), .o_b_rvalid(b_rv1), .o_b_rdata(b_rd1),
      .i_d_req(d_req), .i_d_we(d_we), .i_d_be(d_be), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
      .o_d_gnt(d_gnt1), .o_d_rvalid(d_rv1), .o_d_rdata(d_rd1),
      .i_f_req(f_req), .i_f_addr(f_addr),
      .o_f_gnt(f_gnt1), .o_f_rvalid(f_rv1), .o_f_rdata(f_rd1),
      .o_ram_en(ram_en1), .o_ram_we(ram_we1), .o_ram_be(ram_be1), .o_ram_addr(ram_addr1),
      .o_ram_wdata(ram_wdata1), .i_ram_rdata(ram_rdata1), .o_busy(busy1)
   );

   ram_arbiter #(.ADDR_WIDTH(31), .DATA_WIDTH(31), .READ_LATENCY(3)) dut3 (
      .clk(clk), .clk_en(clk_en), .rst(rst), .i_booted(booted),
      .i_b_req(b_req), .i_b_we(b_we), .i_b_be(b_be), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
      .o_b_gnt(b_gnt3), .o_b_rvalid(b_rv3), .o_b_rdata(b_rd3),
      .i_d_req(d_req), .i_d_we(d_we), .i_d_be(d_be), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
      .o_d_gnt(d_gnt3), .o_d_rvalid(d_rv3), .o_d_rdata(d_rd3),
      .i_f_req(f_req), .i_f_addr(f_addr),
      .o_f_gnt(f_gnt3), .o_f_rvalid(f_rv3), .o_f_rdata(f_rd3),
      .o_ram_en(ram_en3), .o_ram_we(ram_we3), .o_ram_be(ram_be3), .o_ram_addr(ram_addr3),
      .o_ram_wdata(ram_wdata3), .i_ram_rdata(ram_rdata3), .o_busy(busy3)
   );

   // RAM models: word addressed by addr[7:2], pipeline frozen with clk_en like the macro.
   logic [31:0] mem1 [64];
   logic [31:0] mem3 [64];
   logic [31:0] rp1;
   logic [31:0] rp3 [1:3];

   function automatic logic [31:0] bmask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   always @(posedge clk) begin
      if (clk_en) begin
         if (ram_en1 && ram_we1)
            mem1[ram_addr1[7:2]] <= (mem1[ram_addr1[7:2]] & ~bmask(ram_be1)) | (ram_wdata1 & bmask(ram_be1));
         rp1 <= (ram_en1 && !ram_we1) ? mem1[ram_addr1[7:2]] : 32'h0;
         if (ram_en3 && ram_we3)
            mem3[ram_addr3[7:2]] <= (mem3[ram_addr3[7:2]] & ~bmask(ram_be3)) | (ram_wdata3 & bmask(ram_be3));
         rp3[1] <= (ram_en3 && !ram_we3) ? mem3[ram_addr3[7:2]] : 32'h0;
         rp3[2] <= rp3[1];
         rp3[3] <= rp3[2];
      end
   end

   assign ram_rdata1 = rp1;
   assign ram_rdata3 = rp3[3];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      b_req = 1'b0; d_req = 1'b0; f_req = 1'b0;
      repeat (n) cyc();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++;
      if ({b_gnt1, d_gnt1, f_gnt1, b_rv1, d_rv1, f_rv1} !== 6'b0) begin
         bad++; $display("FAIL reset_gnt_rv: got %b want 000000", {b_gnt1, d_gnt1, f_gnt1, b_rv1, d_rv1, f_rv1});
      end
      total++;
      if ({ram_en1, busy1} !== 2'b01) begin
         bad++; $display("FAIL reset_en_busy: got %b want 01", {ram_en1, busy1});
      end
      total++;
      if ({ram_en3, busy3, b_rv3, d_rv3, f_rv3} !== 5'b01000) begin
         bad++; $display("FAIL reset_dut3: got %b want 01000", {ram_en3, busy3, b_rv3, d_rv3, f_rv3});
      end
   endtask

   task automatic test_locked();
      cyc();
      b_req = 1'b1; b_we = 1'b1; b_be = 4'hF; b_addr = 32'h10; b_wdata = 32'hDEADBEEF;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; f_req = 1'b1; f_addr = 32'h10;
      @(negedge clk);
      total++;
      if ({b_gnt1, d_gnt1, f_gnt1} !== 3'b100) begin
         bad++; $display("FAIL locked_wr_gnt: got %b want 100", {b_gnt1, d_gnt1, f_gnt1});
      end
      total++;
      if ({ram_en1, ram_we1, ram_be1, ram_addr1, ram_wdata1} !== {1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF}) begin
         bad++; $display("FAIL locked_wr_cmd: got %b %b %h %h %h want 1 1 f 00000010 deadbeef",
                         ram_en1, ram_we1, ram_be1, ram_addr1, ram_wdata1);
      end
      cyc(); b_we = 1'b0;
      @(negedge clk);
      total++;
      if ({b_gnt1, d_gnt1, f_gnt1, ram_en1, ram_we1} !== 5'b10010) begin
         bad++; $display("FAIL locked_rd_gnt: got %b want 10010", {b_gnt1, d_gnt1, f_gnt1, ram_en1, ram_we1});
      end
      cyc(); b_req = 1'b0;
      @(negedge clk);
      total++;
      if ({b_rv1, d_rv1, f_rv1} !== 3'b100) begin
         bad++; $display("FAIL locked_rvalid: got %b want 100", {b_rv1, d_rv1, f_rv1});
      end
      total++;
      if (b_rd1 !== 32'hDEADBEEF) begin
         bad++; $display("FAIL locked_rdata: got %h want deadbeef", b_rd1);
      end
      total++;
      if ({b_gnt1, d_gnt1, f_gnt1} !== 3'b000) begin
         bad++; $display("FAIL locked_cpu_blocked: got %b want 000", {b_gnt1, d_gnt1, f_gnt1});
      end
      cyc(); d_req = 1'b0; f_req = 1'b0;
      @(negedge clk);
      total++;
      if ({b_rv1, b_rd1} !== {1'b0, 32'hDEADBEEF}) begin
         bad++; $display("FAIL locked_rdata_hold: got %b %h want 0 deadbeef", b_rv1, b_rd1);
      end
      idle(4);
   endtask

   task automatic test_round_robin();
      logic [2:0] want;
      cyc(); booted = 1'b1;
      cyc();
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h10; f_req = 1'b1; f_addr = 32'h10;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) cyc();
         @(negedge clk);
         want = (k % 2 == 0) ? 3'b010 : 3'b001;
         total++;
         if ({b_gnt1, d_gnt1, f_gnt1} !== want) begin
            bad++; $display("FAIL rr_cycle%0d: got %b want %b", k, {b_gnt1, d_gnt1, f_gnt1}, want);
         end
      end
      cyc();
      idle(4);
   endtask

   task automatic test_bios_priority();
      logic [2:0] reqs [7] = '{3'b111, 3'b111, 3'b011, 3'b111, 3'b011, 3'b011, 3'b001};
      logic [2:0] eg   [7] = '{3'b100, 3'b100, 3'b010, 3'b100, 3'b001, 3'b010, 3'b001};
      b_we = 1'b0; b_addr = 32'h10;
      for (int k = 0; k < 7; k++) begin
         cyc();
         {b_req, d_req, f_req} = reqs[k];
         @(negedge clk);
         total++;
         if ({b_gnt1, d_gnt1, f_gnt1} !== eg[k]) begin
            bad++; $display("FAIL prio_cycle%0d: got %b want %b", k, {b_gnt1, d_gnt1, f_gnt1}, eg[k]);
         end
      end
      cyc();
      idle(4);
   endtask

   task automatic test_back_to_back();
      logic [2:0]  eg [6] = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000};
      logic [2:0]  er [6] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 3'b001};
      logic [31:0] got, want;
      for (int k = 0; k < 3; k++) begin
         cyc();
         b_req = 1'b1; b_we = 1'b1; b_be = 4'hF; b_addr = 4 * k; b_wdata = 32'h11111111 * (k + 1);
      end
      for (int k = 0; k < 6; k++) begin
         cyc();
         case (k)
            0: begin b_req = 1'b1; b_we = 1'b0; b_addr = 32'h0; end
            1: begin b_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4; end
            2: begin d_req = 1'b0; f_req = 1'b1; f_addr = 32'h8; end
            default: f_req = 1'b0;
         endcase
         @(negedge clk);
         total++;
         if ({b_gnt3, d_gnt3, f_gnt3, b_rv3, d_rv3, f_rv3} !== {eg[k], er[k]}) begin
            bad++; $display("FAIL b2b_cycle%0d: got %b want %b", k,
                            {b_gnt3, d_gnt3, f_gnt3, b_rv3, d_rv3, f_rv3}, {eg[k], er[k]});
         end
         if (k >= 3) begin
            got  = (k == 3) ? b_rd3 : (k == 4) ? d_rd3 : f_rd3;
            want = 32'h11111111 * (k - 2);
            total++;
            if (got !== want) begin
               bad++; $display("FAIL b2b_rdata%0d: got %h want %h", k, got, want);
            end
         end
      end
      idle(3);
   endtask

   task automatic test_drain();
      logic [3:0] drv [7] = '{4'b1100, 4'b0010, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111};
      logic [2:0] eg  [7] = '{3'b100, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100};
      logic [2:0] er  [7] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 3'b000, 3'b000};
      logic       eb  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      b_we = 1'b0; b_addr = 32'h0; d_we = 1'b0; d_addr = 32'h4; f_addr = 32'h8;
      for (int k = 0; k < 7; k++) begin
         cyc();
         {booted, b_req, d_req, f_req} = drv[k];
         @(negedge clk);
         total++;
         if ({b_gnt3, d_gnt3, f_gnt3, b_rv3, d_rv3, f_rv3, busy3} !== {eg[k], er[k], eb[k]}) begin
            bad++; $display("FAIL drain_cycle%0d: got %b want %b", k,
                            {b_gnt3, d_gnt3, f_gnt3, b_rv3, d_rv3, f_rv3, busy3}, {eg[k], er[k], eb[k]});
         end
         if (k == 3 || k == 4) begin
            total++;
            if (((k == 3) ? b_rd3 : d_rd3) !== ((k == 3) ? 32'h11111111 : 32'h22222222)) begin
               bad++; $display("FAIL drain_rdata%0d: got %h want %h", k, (k == 3) ? b_rd3 : d_rd3,
                               (k == 3) ? 32'h11111111 : 32'h22222222);
            end
         end
      end
      cyc();
      idle(6);
   endtask

   task automatic test_clk_en();
      logic       en   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic       breq [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [2:0] ex   [5] = '{3'b110, 3'b000, 3'b000, 3'b000, 3'b001};
      b_we = 1'b0; b_addr = 32'h10;
      for (int k = 0; k < 5; k++) begin
         cyc();
         clk_en = en[k]; b_req = breq[k];
         @(negedge clk);
         total++;
         if ({b_gnt1, ram_en1, b_rv1} !== ex[k]) begin
            bad++; $display("FAIL clken_cycle%0d: got %b want %b", k, {b_gnt1, ram_en1, b_rv1}, ex[k]);
         end
      end
      total++;
      if (b_rd1 !== 32'hDEADBEEF) begin
         bad++; $display("FAIL clken_rdata: got %h want deadbeef", b_rd1);
      end
      cyc();
      idle(6);
   endtask

   task automatic test_reset_mid();
      logic [7:0] ex [6] = '{8'b10000011, 8'b00000001, 8'b00000001, 8'b00000001, 8'b00000001, 8'b00000001};
      b_we = 1'b0; b_addr = 32'h0;
      for (int k = 0; k < 6; k++) begin
         cyc();
         b_req = (k == 0);
         rst   = (k == 1);
         @(negedge clk);
         total++;
         if ({b_gnt3, d_gnt3, f_gnt3, b_rv3, d_rv3, f_rv3, ram_en3, busy3} !== ex[k]) begin
            bad++; $display("FAIL rstmid_cycle%0d: got %b want %b", k,
                            {b_gnt3, d_gnt3, f_gnt3, b_rv3, d_rv3, f_rv3, ram_en3, busy3}, ex[k]);
         end
      end
   endtask

   initial begin
      clk_en = 1'b1; rst = 1'b1; booted = 1'b0;
      b_req = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = '0; b_wdata = '0;
      d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = '0; d_wdata = '0;
      f_req = 1'b0; f_addr = '0;
      test_reset();
      test_locked();
      test_round_robin();
      test_bios_priority();
      test_back_to_back();
      test_drain();
      test_clk_en();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port program/data RAM between three requesters: the bios loader, the CPU data port and the CPU instruction-fetch port.
- While the system is not booted, the bios owns the RAM exclusively. After boot, the bios keeps fixed priority and the two CPU ports share the remaining bandwidth round-robin.
- Tracks outstanding reads with a tag pipeline so each read word returns only to the requester that issued it.
- Sits between the bios, the core and the RAM macro.

Parameters:
ADDR_WIDTH, 31, MSB index of address buses (bus width ADDR_WIDTH+1)
DATA_WIDTH, 31, MSB index of data buses (bus width DATA_WIDTH+1)
READ_LATENCY, 1, cycles from RAM command edge to valid i_ram_rdata; legal range 1..4

Ports:
clk  in  1  system clock
clk_en  in  1  global clock enable; the RAM macro uses the same enable
rst  in  1  synchronous active-high reset
i_booted  in  1  boot flag from bios; 0 = bios-exclusive mode
i_b_req  in  1  bios request
i_b_we  in  1  bios write (1) / read (0)
i_b_be  in  4  bios byte enables
i_b_addr  in  ADDR_WIDTH+1  bios address
i_b_wdata  in  DATA_WIDTH+1  bios write data
o_b_gnt  out  1  bios request accepted this cycle
o_b_rvalid  out  1  bios read data valid
o_b_rdata  out  DATA_WIDTH+1  bios read data
i_d_req, i_d_we, i_d_be, i_d_addr, i_d_wdata  in  1/1/4/ADDR_WIDTH+1/DATA_WIDTH+1  CPU data port, same meaning as bios port
o_d_gnt, o_d_rvalid, o_d_rdata  out  1/1/DATA_WIDTH+1  CPU data responses
i_f_req  in  1  fetch request (read only)
i_f_addr  in  ADDR_WIDTH+1  fetch address
o_f_gnt, o_f_rvalid, o_f_rdata  out  1/1/DATA_WIDTH+1  fetch responses
o_ram_en  out  1  RAM command valid
o_ram_we  out  1  RAM write
o_ram_be  out  4  RAM byte enables
o_ram_addr  out  ADDR_WIDTH+1  RAM address
o_ram_wdata  out  DATA_WIDTH+1  RAM write data
i_ram_rdata  in  DATA_WIDTH+1  RAM read data
o_busy  out  1  reads outstanding or state != SHARED

Behaviour:
- States: LOCKED, SHARED, DRAIN. Reset enters LOCKED, clears the tag pipeline and the outstanding counter, and sets the round-robin pointer to prefer data.
- Reset values: all o_*_gnt and o_*_rvalid = 0, o_ram_en = 0, o_busy = 1 (LOCKED).
- Handshake: a requester holds req and its command fields stable until it sees gnt=1. Grant is combinational in the cycle of the request, and at most one gnt per cycle. When a grant is issued, o_ram_* carries the granted command that cycle and o_ram_en=1; otherwise o_ram_en=0 and the other RAM fields are don't-care.
- clk_en=0: no grants, o_ram_en=0, state, pointer and tag pipeline frozen. rvalid outputs are held low.
- LOCKED: only bios can be granted; o_d_gnt and o_f_gnt stay 0. Moves to SHARED the cycle after i_booted=1.
- SHARED: bios wins if requesting. Otherwise, if only one CPU port requests, it is granted. If both request, the pointer decides, and the pointer flips to the other port after every CPU grant.
- SHARED -> DRAIN when i_booted=0.
- DRAIN: no new grants. Moves to LOCKED once the outstanding count is 0.
- Reads: each granted read pushes a tag {b,d,f} into a READ_LATENCY-deep shift register.
  - The matching o_x_rvalid pulses exactly READ_LATENCY enabled cycles after the grant cycle, with o_x_rdata = i_ram_rdata.
  - The non-selected rdata outputs hold their previous value.
  - Writes push an empty tag and never produce rvalid.
- Outstanding counter: +1 per read grant, -1 per rvalid. It counts 0..READ_LATENCY and never wraps, because the pipeline bounds it.
- Back-to-back reads from alternating ports in consecutive cycles must return in issue order with no loss.
- Mid-operation rst: outstanding reads are discarded and no rvalid is produced after reset.

Test Plan:
- Bios write 0xDEADBEEF @0x10 then read @0x10 in LOCKED -> o_b_gnt same cycle as req; o_b_rvalid one cycle after the read grant with rdata 0xDEADBEEF. Asserting i_d_req and i_f_req in LOCKED -> no grants.
- i_booted=1, i_d_req and i_f_req held together for 6 cycles -> grants alternate d,f,d,f,d,f (data first after reset).
- SHARED with bios, data and fetch all requesting -> bios granted every cycle it requests; CPU ports are granted only in cycles where bios req=0.
- READ_LATENCY=3: reads b@0, d@4, f@8 in consecutive cycles -> rvalid b, d, f in consecutive cycles, each 3 cycles after its grant, with correct words.
- Drop i_booted with 2 reads outstanding -> DRAIN, no grants until both rvalids seen, then LOCKED; o_busy=1 throughout.
- Assert rst with a read outstanding; separately hold clk_en=0 for 3 cycles mid-read -> after rst, no rvalid and all outputs at reset values; with clk_en=0, rvalid is delayed by exactly 3 cycles.
